// File: rtl/sd_cmd_resp_rx.sv
// sd_cmd_resp_rx: SD CMD-line response receiver.
// Hunts for the start bit after a command, deserialises a 48-bit or 136-bit
// response, checks CRC-7, transmission bit and end bit, enforces the NCR
// timeout and presents the payload with a one-cycle done_o pulse.
// Optional feature macro: SD_RESP_RX_BUSY_EN adds R1b busy waiting on DAT0
// (ports dat0_i, wait_busy_i and a BUSY state). Default build leaves it out.
//
// Handshake: start_i is accepted only in IDLE (busy_o=0, done_o=0); from the
// following cycle busy_o stays high until the receive completes, then done_o
// pulses for exactly one clock while busy_o is low. Status and resp_o are
// valid from the done_o cycle and held until the next accepted start_i.
// state_o exposes the FSM state for debug and checkers.

module sd_cmd_resp_rx #(
  parameter int          TIMEOUT_STROBES = 64,
  parameter logic [6:0]  CRC_POLY        = 7'h09
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          bit_stb_i,
  input  logic          cmd_i,
  input  logic          start_i,
  input  logic          long_i,
  input  logic          no_crc_i,
`ifdef SD_RESP_RX_BUSY_EN
  input  logic          dat0_i,
  input  logic          wait_busy_i,
`endif
  output logic          busy_o,
  output logic          done_o,
  output logic [119:0]  resp_o,
  output logic          timeout_o,
  output logic          crc_err_o,
  output logic          frame_err_o,
  output logic [2:0]    state_o
);

  localparam int             TW      = $clog2(TIMEOUT_STROBES + 1);
  localparam logic [TW-1:0]  TO_LAST = TW'(TIMEOUT_STROBES - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_START = 3'd1,
    S_RECV       = 3'd2,
    S_DONE       = 3'd3
`ifdef SD_RESP_RX_BUSY_EN
    ,
    S_BUSY       = 3'd4
`endif
  } state_t;

  state_t          state_q;
  state_t          state_d;

  logic            long_q;
  logic            no_crc_q;
`ifdef SD_RESP_RX_BUSY_EN
  logic            wait_busy_q;
`endif

  // bit_cnt_q counts frame bits consumed so far (start bit included)
  logic [7:0]      bit_cnt_q;
  logic [TW-1:0]   to_cnt_q;
  // sr_q[k] holds frame bit k+1 once the end bit arrives
  logic [126:0]    sr_q;
  logic [6:0]      crc_q;

  logic [7:0]      last_idx;
  logic [7:0]      bit_idx;
  logic            crc_fb;
  logic [6:0]      crc_next;
  logic            in_crc_window;

  // Position of the bit currently on the line, counted MSB first
  assign last_idx = long_q ? 8'd135 : 8'd47;
  assign bit_idx  = last_idx - bit_cnt_q;

  // Serial CRC-7 step for the bit currently on the line
  assign crc_fb   = cmd_i ^ crc_q[6];
  assign crc_next = {crc_q[5:0], 1'b0} ^ (crc_fb ? CRC_POLY : 7'h00);

  // Short frames cover bits 47..1 (start bit already folded in as zero);
  // long frames skip the 8-bit header and cover bits 127..1
  assign in_crc_window = (bit_idx != 8'd0) && (!long_q || (bit_idx <= 8'd127));

  assign state_o = state_q;

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and handshake outputs
  always_comb begin
    state_d = state_q;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_WAIT_START;
        end
      end
      S_WAIT_START: begin
        busy_o = 1'b1;
        if (bit_stb_i) begin
          if (!cmd_i) begin
            state_d = S_RECV;
          end else if (to_cnt_q == TO_LAST) begin
            state_d = S_DONE;
          end
        end
      end
      S_RECV: begin
        busy_o = 1'b1;
        if (bit_stb_i && (bit_idx == 8'd0)) begin
`ifdef SD_RESP_RX_BUSY_EN
          state_d = wait_busy_q ? S_BUSY : S_DONE;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef SD_RESP_RX_BUSY_EN
      S_BUSY: begin
        busy_o = 1'b1;
        if (bit_stb_i && dat0_i) begin
          state_d = S_DONE;
        end
      end
`endif
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Datapath: option latches, counters, shift register, CRC and status
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      long_q      <= 1'b0;
      no_crc_q    <= 1'b0;
`ifdef SD_RESP_RX_BUSY_EN
      wait_busy_q <= 1'b0;
`endif
      bit_cnt_q   <= 8'd0;
      to_cnt_q    <= '0;
      sr_q        <= '0;
      crc_q       <= 7'd0;
      resp_o      <= 120'd0;
      timeout_o   <= 1'b0;
      crc_err_o   <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            long_q      <= long_i;
            no_crc_q    <= no_crc_i;
`ifdef SD_RESP_RX_BUSY_EN
            wait_busy_q <= wait_busy_i;
`endif
            bit_cnt_q   <= 8'd0;
            to_cnt_q    <= '0;
            sr_q        <= '0;
            crc_q       <= 7'd0;
            resp_o      <= 120'd0;
            timeout_o   <= 1'b0;
            crc_err_o   <= 1'b0;
            frame_err_o <= 1'b0;
          end
        end
        S_WAIT_START: begin
          if (bit_stb_i) begin
            if (!cmd_i) begin
              // Start bit consumed; it would feed a zero into a cleared CRC
              bit_cnt_q <= 8'd1;
              crc_q     <= 7'd0;
            end else begin
              to_cnt_q <= to_cnt_q + TW'(1);
              if (to_cnt_q == TO_LAST) begin
                timeout_o <= 1'b1;
              end
            end
          end
        end
        S_RECV: begin
          if (bit_stb_i) begin
            bit_cnt_q <= bit_cnt_q + 8'd1;
            if (bit_idx != 8'd0) begin
              sr_q <= {sr_q[125:0], cmd_i};
            end
            if (in_crc_window) begin
              crc_q <= crc_next;
            end
            // Transmission bit directly follows the start bit
            if ((bit_cnt_q == 8'd1) && cmd_i) begin
              frame_err_o <= 1'b1;
            end
            // Last received CRC bit: remainder must be zero
            if ((bit_idx == 8'd1) && !no_crc_q && (crc_next != 7'd0)) begin
              crc_err_o <= 1'b1;
            end
            if (bit_idx == 8'd0) begin
              if (!cmd_i) begin
                frame_err_o <= 1'b1;
              end
              resp_o <= long_q ? sr_q[126:7] : {82'd0, sr_q[44:7]};
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
